// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: DEPTH-entry in-order queue of MEM results, retiring at most
// one instruction per cycle and collapsing exception/ertn/refetch into one flush.
module wb_commit_stage #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 2,
    parameter int NUM_CAUSE = 6,
    // Slot i (bits [6i+5:6i]) holds the ecode for cause bit i; slot 0 is the rightmost field.
    parameter logic [6*NUM_CAUSE-1:0] ECODE_TABLE = {6'h00, 6'h09, 6'h0d, 6'h08, 6'h0c, 6'h0b}
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ms_to_ws_valid,
    output logic              ws_allowin,
    input  logic [DATA_W-1:0] ms_pc,
    input  logic [DATA_W-1:0] ms_result,
    input  logic [DATA_W-1:0] ms_badv,
    input  logic              ms_gr_we,
    input  logic [4:0]        ms_dest,
    input  logic              ms_csr_rd,
    input  logic [NUM_CAUSE-1:0] ms_cause,
    input  logic              ms_ertn,
    input  logic              ms_refetch,
    input  logic              wb_hold,
    output logic              csr_re,
    input  logic [DATA_W-1:0] csr_rvalue,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_ex,
    output logic [5:0]        wb_ecode,
    output logic [DATA_W-1:0] wb_pc,
    output logic [DATA_W-1:0] wb_vaddr,
    output logic              wb_ertn,
    output logic              wb_refetch,
    output logic [DATA_W-1:0] refetch_pc,
    input  logic [4:0]        fwd_dest,
    output logic              fwd_hit,
    output logic              fwd_block,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    result;
        logic [DATA_W-1:0]    badv;
        logic                 gr_we;
        logic [4:0]           dest;
        logic                 csr_rd;
        logic [NUM_CAUSE-1:0] cause;
        logic                 ertn;
        logic                 refetch;
    } entry_t;

    entry_t           q [DEPTH];
    entry_t           h;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             head_valid;
    logic             fire;
    logic             enq;
    logic             ex_any;
    logic             flush;
    logic             retire;
    logic [5:0]       ecode_sel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1) return '0;
        else return p + PTR_W'(1);
    endfunction

    // MEM->WB handshake: an entry moves when ms_to_ws_valid and ws_allowin are both high in
    // the same cycle (and no flush is retiring); while ws_allowin is low MEM holds its bus.
    assign head_valid = (count != '0);
    assign h          = q[head];
    assign fire       = head_valid & ~wb_hold;
    assign ws_allowin = (count != CNT_W'(DEPTH)) | fire;
    assign enq        = ms_to_ws_valid & ws_allowin & ~flush;

    assign ex_any     = head_valid & (|h.cause);
    assign wb_ex      = fire & ex_any;
    assign wb_ertn    = fire & h.ertn & ~ex_any;
    assign wb_refetch = fire & h.refetch & ~ex_any;
    assign flush      = wb_ex | wb_ertn | wb_refetch;
    assign retire     = fire & ~ex_any & ~h.refetch;

    // Lowest set cause bit wins, so scan from the top down and let later hits overwrite.
    always_comb begin
        ecode_sel = '0;
        for (int i = NUM_CAUSE - 1; i >= 0; i--) begin
            if (h.cause[i]) ecode_sel = ECODE_TABLE[6*i +: 6];
        end
    end

    assign wb_ecode   = head_valid ? ecode_sel : '0;
    assign wb_pc      = head_valid ? h.pc : '0;
    assign wb_vaddr   = head_valid ? h.badv : '0;
    assign refetch_pc = head_valid ? h.pc : '0;
    assign csr_re     = head_valid & h.csr_rd;
    assign rf_we      = fire & h.gr_we & ~ex_any & ~h.refetch;
    assign rf_waddr   = head_valid ? h.dest : '0;
    assign rf_wdata   = head_valid ? (h.csr_rd ? csr_rvalue : h.result) : '0;

    assign debug_wb_pc       = 32'(wb_pc);
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = 32'(rf_wdata);

    // Walk entries oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_block = 1'b0;
        fwd_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)
                && q[PTR_W'((int'(head) + i) % DEPTH)].gr_we
                && q[PTR_W'((int'(head) + i) % DEPTH)].dest != 5'd0
                && q[PTR_W'((int'(head) + i) % DEPTH)].dest == fwd_dest
                && ~|q[PTR_W'((int'(head) + i) % DEPTH)].cause) begin
                fwd_hit   = 1'b1;
                fwd_block = q[PTR_W'((int'(head) + i) % DEPTH)].csr_rd;
                fwd_data  = q[PTR_W'((int'(head) + i) % DEPTH)].result;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            retired_cnt <= '0;
        end else begin
            if (retire) retired_cnt <= retired_cnt + 32'd1;
            if (flush) begin
                count <= '0;
                head  <= tail;
            end else begin
                if (enq)  tail <= ptr_inc(tail);
                if (fire) head <= ptr_inc(head);
                count <= count + CNT_W'(enq) - CNT_W'(fire);
            end
        end
    end

    // Payload needs no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            q[tail] <= '{pc: ms_pc, result: ms_result, badv: ms_badv, gr_we: ms_gr_we,
                         dest: ms_dest, csr_rd: ms_csr_rd, cause: ms_cause,
                         ertn: ms_ertn, refetch: ms_refetch};
        end
    end

endmodule
